// File: rtl/mppc_dark_counter_pkg.sv
// Shared types and constants for the MPPC dark-count meter.
// The ASCII constants and hex_to_ascii are used only when the
// DARK_COUNTER_ASCII_EN build option is defined.
package mppc_dark_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_SEND  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam logic [7:0] START_CMD = 8'h53;  // 'S'
  localparam logic [7:0] ASCII_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] ASCII_OVF = 8'h4F;  // 'O'
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/mppc_dark_counter_uart_tx.sv
// 8N1 UART transmitter with a byte/valid/ready handshake.
// ready_o is also raised in the final cycle of a stop bit so a waiting
// byte follows with no idle gap.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       txd_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

  logic              busy_q, busy_d;
  logic [9:0]        shift_q, shift_d;
  logic [3:0]        bits_q, bits_d;
  logic [BAUD_W-1:0] baud_q, baud_d;

  assign ready_o = !busy_q || (baud_q == '0 && bits_q == '0);
  assign txd_o   = busy_q ? shift_q[0] : 1'b1;

  // Next-state: load a frame on handshake, otherwise shift out one bit per baud period.
  always_comb begin
    busy_d  = busy_q;
    shift_d = shift_q;
    bits_d  = bits_q;
    baud_d  = baud_q;
    if (valid_i && ready_o) begin
      busy_d  = 1'b1;
      shift_d = {1'b1, data_i, 1'b0};
      bits_d  = 4'd9;
      baud_d  = BAUD_RELOAD;
    end else if (busy_q) begin
      if (baud_q == '0) begin
        if (bits_q == '0) begin
          busy_d = 1'b0;
        end else begin
          shift_d = {1'b1, shift_q[9:1]};
          bits_d  = bits_q - 1'b1;
          baud_d  = BAUD_RELOAD;
        end
      end else begin
        baud_d = baud_q - 1'b1;
      end
    end
  end

  // Transmitter registers; reset returns the line to idle-high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q  <= 1'b0;
      shift_q <= '1;
      bits_q  <= '0;
      baud_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      shift_q <= shift_d;
      bits_q  <= bits_d;
      baud_q  <= baud_d;
    end
  end

endmodule

// File: rtl/mppc_dark_counter_uart.sv
// MPPC dark-count meter: counts synchronized pulse_in rising edges over a
// fixed gate and reports the result over UART.
// Build option DARK_COUNTER_ASCII_EN: ASCII frame ('K'/'O', hex digits, CR LF);
// undefined gives the binary frame (status byte, then count MSB first).
//
// state    | meaning
// ST_IDLE  | waiting for button edge or START_CMD byte
// ST_COUNT | gate open, counting pulses
// ST_SEND  | transmitting the result frame
module mppc_dark_counter_uart #(
  parameter int         CLK_FREQ_HZ = 100_000_000,
  parameter int         BAUD        = 115_200,
  parameter int         GATE_CYCLES = 100_000_000,
  parameter int         CNT_WIDTH   = 32,
  parameter logic [7:0] START_CMD   = mppc_dark_counter_pkg::START_CMD
) (
  input  logic clk,
  input  logic rst_button,
  input  logic start_button,
  input  logic RxD,
  input  logic pulse_in,
  output logic TxD,
  output logic busy_led,
  output logic overflow_led
);

  import mppc_dark_counter_pkg::*;

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int GATE_W       = $clog2(GATE_CYCLES);
`ifdef DARK_COUNTER_ASCII_EN
  localparam int NHEX         = CNT_WIDTH / 4;
  localparam int FRAME_BYTES  = NHEX + 3;
`else
  localparam int NBIN         = CNT_WIDTH / 8;
  localparam int FRAME_BYTES  = NBIN + 1;
`endif
  localparam int IDX_W        = $clog2(FRAME_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  logic [1:0] start_sync_q, rxd_sync_q, pulse_sync_q;
  logic       start_prev_q, rxd_prev_q, pulse_prev_q;
  logic       rxd_s, start_rise, pulse_rise;

  // Two-flop synchronizers plus a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst_button) begin
      start_sync_q <= 2'b00;
      rxd_sync_q   <= 2'b11;
      pulse_sync_q <= 2'b00;
      start_prev_q <= 1'b0;
      rxd_prev_q   <= 1'b1;
      pulse_prev_q <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[0], start_button};
      rxd_sync_q   <= {rxd_sync_q[0], RxD};
      pulse_sync_q <= {pulse_sync_q[0], pulse_in};
      start_prev_q <= start_sync_q[1];
      rxd_prev_q   <= rxd_sync_q[1];
      pulse_prev_q <= pulse_sync_q[1];
    end
  end

  assign rxd_s      = rxd_sync_q[1];
  assign start_rise = start_sync_q[1] & ~start_prev_q;
  assign pulse_rise = pulse_sync_q[1] & ~pulse_prev_q;

  rx_state_e         rx_state_q, rx_state_d;
  logic [BAUD_W-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic [7:0]        rx_byte_q, rx_byte_d;
  logic              rx_vld_q, rx_vld_d;

  // UART receiver: arm on falling edge, confirm start at half bit, sample mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_vld_d   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_s) begin
          rx_state_d = RX_START;
          rx_baud_d  = BAUD_W'(CLKS_PER_BIT / 2 - 1);
        end
      end
      RX_START: begin
        if (rx_baud_q == '0) begin
          if (rxd_s) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = '0;
            rx_baud_d  = BAUD_W'(CLKS_PER_BIT - 1);
          end
        end else begin
          rx_baud_d = rx_baud_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_baud_q == '0) begin
          rx_shift_d = {rxd_s, rx_shift_q[7:1]};
          rx_baud_d  = BAUD_W'(CLKS_PER_BIT - 1);
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_baud_d = rx_baud_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_baud_q == '0) begin
          rx_state_d = RX_IDLE;
          if (rxd_s) begin
            rx_vld_d  = 1'b1;
            rx_byte_d = rx_shift_q;
          end
        end else begin
          rx_baud_d = rx_baud_q - 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver registers.
  always_ff @(posedge clk) begin
    if (rst_button) begin
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_vld_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_vld_q   <= rx_vld_d;
    end
  end

  logic start_req;
  assign start_req = start_rise | (rx_vld_q && rx_byte_q == START_CMD);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [GATE_W-1:0]    gate_q, gate_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 all_sent_q, all_sent_d;
  logic                 tx_valid, tx_ready;
  logic [7:0]           tx_data;

  assign tx_valid = (state_q == ST_SEND) && !all_sent_q;

  // Measurement FSM: start, gated counting with saturation, then frame handoff.
  // After the last byte is handed off, wait for its stop bit to end before IDLE.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    gate_d     = gate_q;
    idx_d      = idx_q;
    all_sent_d = all_sent_q;
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          count_d = '0;
          ovf_d   = 1'b0;
          gate_d  = GATE_W'(GATE_CYCLES - 1);
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (pulse_rise) begin
          if (&count_q) ovf_d   = 1'b1;
          else          count_d = count_q + 1'b1;
        end
        if (gate_q == '0) begin
          state_d    = ST_SEND;
          idx_d      = '0;
          all_sent_d = 1'b0;
        end else begin
          gate_d = gate_q - 1'b1;
        end
      end
      ST_SEND: begin
        if (all_sent_q) begin
          if (tx_ready) state_d = ST_IDLE;
        end else if (tx_ready) begin
          if (idx_q == LAST_IDX) all_sent_d = 1'b1;
          else                   idx_d      = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and measurement registers.
  always_ff @(posedge clk) begin
    if (rst_button) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      gate_q     <= '0;
      idx_q      <= '0;
      all_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      gate_q     <= gate_d;
      idx_q      <= idx_d;
      all_sent_q <= all_sent_d;
    end
  end

  // Frame byte selected by idx_q; count is frozen while in SEND.
  always_comb begin
    tx_data = 8'h00;
`ifdef DARK_COUNTER_ASCII_EN
    if (idx_q == '0) tx_data = ovf_q ? ASCII_OVF : ASCII_OK;
    for (int i = 0; i < NHEX; i++) begin
      if (idx_q == IDX_W'(i + 1)) tx_data = hex_to_ascii(count_q[(NHEX-1-i)*4 +: 4]);
    end
    if (idx_q == IDX_W'(NHEX + 1)) tx_data = ASCII_CR;
    if (idx_q == IDX_W'(NHEX + 2)) tx_data = ASCII_LF;
`else
    if (idx_q == '0) tx_data = {7'b0, ovf_q};
    for (int i = 0; i < NBIN; i++) begin
      if (idx_q == IDX_W'(i + 1)) tx_data = count_q[(NBIN-1-i)*8 +: 8];
    end
`endif
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk_i  (clk),
    .rst_i  (rst_button),
    .data_i (tx_data),
    .valid_i(tx_valid),
    .ready_o(tx_ready),
    .txd_o  (TxD)
  );

  assign busy_led     = (state_q != ST_IDLE);
  assign overflow_led = ovf_q;

endmodule

// File: tb/tb_mppc_dark_counter_uart.sv
// Bench for mppc_dark_counter_uart with a fast UART (16 clocks per bit),
// 1000-cycle gate and 8-bit counter. Expected frames are queued when a
// measurement is issued; a TxD decoder process pops and compares them.
module tb_mppc_dark_counter_uart;

  localparam int CPB  = 16;
  localparam int GATE = 1000;
`ifdef DARK_COUNTER_ASCII_EN
  localparam int NFRAME = 5;
`else
  localparam int NFRAME = 2;
`endif
  localparam int SEND_BUDGET = GATE + NFRAME * 10 * CPB + 200;

  logic clk = 1'b0;
  logic rst_button, start_button, RxD, pulse_in;
  logic TxD, busy_led, overflow_led;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  mppc_dark_counter_uart #(
    .CLK_FREQ_HZ(100_000_000),
    .BAUD       (6_250_000),
    .GATE_CYCLES(GATE),
    .CNT_WIDTH  (8),
    .START_CMD  (8'h53)
  ) dut (
    .clk         (clk),
    .rst_button  (rst_button),
    .start_button(start_button),
    .RxD         (RxD),
    .pulse_in    (pulse_in),
    .TxD         (TxD),
    .busy_led    (busy_led),
    .overflow_led(overflow_led)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // TxD decoder: samples each bit at its middle and scores the byte.
  initial begin : monitor
    logic [7:0] b;
    logic stop_bit;
    forever begin
      @(negedge clk);
      if (TxD === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        check("tx_start_bit", TxD, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = TxD;
        end
        repeat (CPB) @(negedge clk);
        stop_bit = TxD;
        check("tx_stop_bit", stop_bit, 1'b1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx_byte actual=%02h expected=none", b);
        end else begin
          check("tx_byte", b, exp_q.pop_front());
        end
      end
    end
  end

  task automatic uart_send(input logic [7:0] b);
    RxD = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (CPB) @(negedge clk);
    end
    RxD = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic press_button();
    start_button = 1'b1;
    repeat (5) @(negedge clk);
    start_button = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_busy(input logic want, input int budget, input string name);
    int k = 0;
    while (busy_led !== want && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, busy_led, want);
  endtask

  // n rising edges; toggle mode flips the line every clock.
  task automatic gen_pulses(input int n, input bit tog);
    for (int i = 0; i < n; i++) begin
      pulse_in = 1'b1;
      @(negedge clk);
      pulse_in = 1'b0;
      repeat (tog ? 1 : $urandom_range(1, 2)) @(negedge clk);
    end
  endtask

  // Reference frame: saturating count of all pulses issued inside the gate.
  task automatic push_expected(input int n);
    int   cnt;
    bit   ovf;
    string s;
    cnt = (n > 255) ? 255 : n;
    ovf = (n > 255);
`ifdef DARK_COUNTER_ASCII_EN
    exp_q.push_back(ovf ? 8'h4F : 8'h4B);
    s = $sformatf("%02X", cnt);
    exp_q.push_back(s[0]);
    exp_q.push_back(s[1]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    s = "";
    exp_q.push_back({7'b0, ovf});
    exp_q.push_back(8'(cnt));
`endif
  endtask

  // One full measurement; poke presses the button once in COUNT and once in SEND.
  task automatic measure(input int n, input bit tog, input bit via_uart, input bit poke);
    if (via_uart) uart_send(8'h53);
    else          press_button();
    wait_busy(1'b1, 40, "busy_rise");
    push_expected(n);
    fork
      gen_pulses(n, tog);
      begin
        if (poke) begin
          repeat (150) @(negedge clk);
          press_button();
          repeat (940) @(negedge clk);
          press_button();
        end
      end
    join
    wait_busy(1'b0, SEND_BUDGET, "busy_fall");
    check("overflow_led", overflow_led, (n > 255) ? 1'b1 : 1'b0);
    repeat (5) @(negedge clk);
    check("frame_consumed", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    logic [7:0] b;
    rst_button   = 1'b1;
    start_button = 1'b0;
    RxD          = 1'b1;
    pulse_in     = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_txd", TxD, 1'b1);
    check("rst_busy", busy_led, 1'b0);
    check("rst_ovf", overflow_led, 1'b0);
    rst_button = 1'b0;
    repeat (5) @(negedge clk);

    // false starts: short glitch and a 2000 ns low
    RxD = 1'b0;
    repeat (3) @(negedge clk);
    RxD = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_busy", busy_led, 1'b0);
    RxD = 1'b0;
    repeat (200) @(negedge clk);
    RxD = 1'b1;
    repeat (200) @(negedge clk);
    check("long_low_busy", busy_led, 1'b0);
    check("long_low_txd", TxD, 1'b1);

    // bytes other than the start command must not start a measurement
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h53) b = 8'h52;
      uart_send(b);
      repeat (30) @(negedge clk);
      check("non_cmd_busy", busy_led, 1'b0);
    end

    measure(37, 1'b0, 1'b1, 1'b0);
    measure(400, 1'b1, 1'b0, 1'b1);
    measure(0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(0, 280);
      if (n == 255) n = 256;
      measure(n, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // reset mid-COUNT after overflow has been raised
    press_button();
    wait_busy(1'b1, 40, "busy_rise_rst");
    gen_pulses(300, 1'b1);
    check("ovf_live", overflow_led, 1'b1);
    rst_button = 1'b1;
    @(negedge clk);
    check("abort_busy", busy_led, 1'b0);
    check("abort_txd", TxD, 1'b1);
    check("abort_ovf", overflow_led, 1'b0);
    rst_button = 1'b0;
    repeat (GATE + 400) @(negedge clk);
    check("abort_no_frame_busy", busy_led, 1'b0);

    n = $urandom_range(1, 200);
    measure(n, 1'b0, 1'b1, 1'b0);

    repeat (50) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
